fft4_input_framer: RTL and testbench
====================================

# fft4_input_framer

Upstream stage for the combinational `fft4` core. It accepts a serial stream of complex samples, one per cycle, through a valid/ready handshake. It packs each group of four consecutive samples into a frame and presents that frame in parallel on `x0..x3` with a frame-level valid/ready handshake. Two frame banks (ping-pong) let the next frame fill while the previous frame waits to be consumed, so 1 sample/cycle is sustained.

## Interface
Parameters:
- `DATA_W`, 16: width of each real or imaginary component, two's complement, passed through unmodified.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: framer can accept a sample.
- `s_sof` in 1: start-of-frame marker, qualified by `s_valid`.
- `s_re`, `s_im` in DATA_W each: input sample.
- `m_valid` out 1: full frame present on `x*`.
- `m_ready` in 1: downstream consumes the frame.
- `x0_re`, `x0_im` … `x3_re`, `x3_im` out DATA_W each: frame samples in arrival order (x0 = first).
- `err_misalign` out 1: one-cycle pulse when a partial frame is discarded.

## Operation
- Accept occurs when `s_valid && s_ready`. Sample is written to slot `idx` of write bank `wr_sel`. `idx` is 2 bits, 0→3.
- On accept with `idx==3`:
  - `full[wr_sel]` is set.
  - `wr_sel` toggles.
  - `idx` returns to 0.
- Otherwise, on accept, `idx` increments.
- `s_ready = !full[wr_sel]`.
- `m_valid = full[rd_sel]`. `x*` are driven from bank `rd_sel` regardless of `m_valid`.
- On `m_valid && m_ready`, `full[rd_sel]` clears and `rd_sel` toggles.
- Write and read in the same cycle always target different banks, because a bank is writable only when empty and readable only when full. Both updates take effect.
- Misalignment: on accept with `s_sof=1` and `idx!=0`:
  - The partial frame is dropped.
  - The accepted sample is written to slot 0 of the same bank, and `idx` becomes 1.
  - `err_misalign` is high for the following cycle.
- `s_sof=1` with `idx==0` is normal.
- `s_sof=0` at `idx==0` is accepted as a frame start; no error.
- Reset:
  - `idx=0`, `wr_sel=0`, `rd_sel=0`, `full=2'b00`.
  - All bank registers are 0, so all `x*` read 0.
  - `m_valid=0`, `err_misalign=0`.
  - `s_ready=1` from the first cycle after reset.
- Reset asserted mid-frame or with frames pending discards everything. No partial or pending frame is ever presented after reset.
- Bank contents are not cleared on read. A stale frame remains visible on `x*` with `m_valid=0`.

## Timing
- Latency: 4th sample accepted in cycle N → `m_valid=1` and frame stable on `x*` in cycle N+1.
- `x*` and `m_valid` are registered-state driven; no combinational path from `s_*` to `x*`/`m_valid`.
- `s_ready` depends only on registered state, not on `m_ready` in the same cycle. A bank freed in cycle N is writable in N+1.
- Full condition: both banks full → `s_ready=0` until a frame is consumed.
- With `m_ready` held high and continuous `s_valid`:
  - `s_ready` never deasserts.
  - One frame emits every 4 cycles.
- `m_valid` stays high and `x*` stay stable until `m_ready`; no retraction.

## Structure
- Shared package `fft4_pkg`:
  - `localparam FFT_N = 4`.
  - `localparam IDX_W = 2`.
  - Packed struct typedef for a complex sample (`re`, `im`) at the default width, reused by the `fft4` neighbours.
- Sub-module `fft4_framer_bank`:
  - One 4-entry complex register bank with write enable, 2-bit write index and synchronous reset to 0.
  - All four entries exposed in parallel.
  - Instantiated twice.
- The top level holds `idx`, `wr_sel`, `rd_sel`, `full[1:0]`, the error pulse register and the output mux.

## Test plan
- **Single frame:** after reset, stream (1,0),(2,0),(3,0),(4,0) with `m_ready=0`.
  - `m_valid` rises the cycle after the 4th accept.
  - Frame reads x0=1, x1=2, x2=3, x3=4.
  - Frame holds while `m_ready=0`.
- **Backpressure full:** `m_ready=0`, stream 12 samples 1..12.
  - `s_ready` drops after sample 8.
  - On one `m_ready` pulse: frame 1..4 is consumed and frame 5..8 appears the next cycle.
  - `s_ready` rises and samples 9..12 fill.
- **Sustained rate:** `m_ready=1`, 16 continuous samples 0..15.
  - `s_ready` stays 1 throughout.
  - Four frames emitted 4 cycles apart: {0..3}, {4..7}, {8..11}, {12..15}.
- **Misalignment:** send 10, 11, then 20 with `s_sof=1`, then 21, 22, 23.
  - `err_misalign` pulses once.
  - Emitted frame is 20, 21, 22, 23.
- **Simultaneous read/write:** bank 0 full, bank 1 receiving its 4th sample while `m_ready=1`, all in the same cycle.
  - Next cycle: `full=2'b10`, `rd_sel=1`, `m_valid=1` with the new frame.
- **Reset mid-operation:** assert `rst` with one frame pending and 2 samples in the fill bank.
  - Next cycle: `m_valid=0`, all `x*`=0, `s_ready=1`.
  - A subsequent full frame emits correctly.

Source files
------------

// File: rtl/fft4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft4_pkg
//  Description : Shared constants and types for the fft4 datapath family.
//                FFT_N  - points per transform (samples per frame)
//                IDX_W  - width of a slot index within a frame
//                cplx_t - complex sample at the default component width
//  Revision    : 1.0 - initial release
// ============================================================================
package fft4_pkg;

    localparam int FFT_N        = 4;
    localparam int IDX_W        = 2;
    localparam int CPLX_W_DEF   = 16;

    typedef struct packed {
        logic signed [CPLX_W_DEF-1:0] re;
        logic signed [CPLX_W_DEF-1:0] im;
    } cplx_t;

endpackage
`default_nettype wire

// File: rtl/fft4_input_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft4_input_framer_if
//  Description : Bundle of the framer's sample-side and frame-side signals.
//                Sample side : s_valid, s_ready, s_sof, s_re, s_im
//                Frame side  : m_valid, m_ready, x0..x3 (re/im), err_misalign
//                modport master : the framer (accepts samples, sources frames)
//                modport slave  : the surrounding environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft4_input_framer_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic              s_sof;
    logic [DATA_W-1:0] s_re;
    logic [DATA_W-1:0] s_im;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] x0_re, x0_im;
    logic [DATA_W-1:0] x1_re, x1_im;
    logic [DATA_W-1:0] x2_re, x2_im;
    logic [DATA_W-1:0] x3_re, x3_im;
    logic              err_misalign;

    modport master (
        input  s_valid, s_sof, s_re, s_im, m_ready,
        output s_ready, m_valid,
        output x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
        output err_misalign
    );

    modport slave (
        output s_valid, s_sof, s_re, s_im, m_ready,
        input  s_ready, m_valid,
        input  x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
        input  err_misalign
    );
endinterface
`default_nettype wire

// File: rtl/fft4_framer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fft4_framer_bank
//  Description : One frame bank: FFT_N complex registers, written one slot at
//                a time, all slots visible in parallel. Cleared by reset only.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_we, i_idx     - write enable and slot index
//                i_re, i_im      - sample to write
//                o_re, o_im      - all slots, slot 0 in element [0]
//  Revision    : 1.0 - initial release
// ============================================================================
module fft4_framer_bank
    import fft4_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_we,
    input  wire logic [IDX_W-1:0]              i_idx,
    input  wire logic [DATA_W-1:0]             i_re,
    input  wire logic [DATA_W-1:0]             i_im,
    output logic      [FFT_N-1:0][DATA_W-1:0]  o_re,
    output logic      [FFT_N-1:0][DATA_W-1:0]  o_im
);

    logic [FFT_N-1:0][DATA_W-1:0] r_re;
    logic [FFT_N-1:0][DATA_W-1:0] r_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_re <= '0;
            r_im <= '0;
        end else if (i_we) begin
            r_re[i_idx] <= i_re;
            r_im[i_idx] <= i_im;
        end
    end

    assign o_re = r_re;
    assign o_im = r_im;

endmodule
`default_nettype wire

// File: rtl/fft4_input_framer.sv
`default_nettype none
// ============================================================================
//  Module      : fft4_input_framer
//  Description : Packs a serial complex sample stream into 4-sample frames
//                using two ping-pong banks, sustaining 1 sample/cycle.
//                A start-of-frame marker arriving mid-frame drops the partial
//                frame and restarts it, pulsing err_misalign one cycle later.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - fft4_input_framer_if.master (sample in, frame out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fft4_input_framer
    import fft4_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fft4_input_framer_if.master  bus
);

    logic [IDX_W-1:0] r_idx;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [1:0]       r_full;
    logic             r_err;

    logic             w_accept;
    logic             w_consume;
    logic             w_misalign;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_last;
    logic [1:0]       w_wr_en;
    logic [1:0]       w_full_nxt;

    logic [1:0][FFT_N-1:0][DATA_W-1:0] w_bank_re;
    logic [1:0][FFT_N-1:0][DATA_W-1:0] w_bank_im;

    // Ready and valid come purely from registered bank occupancy.
    assign bus.s_ready = ~r_full[r_wr_sel];
    assign bus.m_valid = r_full[r_rd_sel];

    assign w_accept   = bus.s_valid & bus.s_ready;
    assign w_consume  = bus.m_valid & bus.m_ready;
    assign w_misalign = w_accept & bus.s_sof & (r_idx != '0);

    // A misaligned start overwrites slot 0 of the same bank, discarding the
    // partial frame without any explicit clear.
    assign w_wr_idx = w_misalign ? '0 : r_idx;
    assign w_last   = w_accept & (w_wr_idx == IDX_W'(FFT_N - 1));
    assign w_wr_en  = w_accept ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;

    // Write and read always hit different banks, so both updates apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_consume) w_full_nxt[r_rd_sel] = 1'b0;
        if (w_last)    w_full_nxt[r_wr_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_full   <= 2'b00;
            r_err    <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            r_err  <= w_misalign;
            if (w_accept) begin
                if (w_last) begin
                    r_idx    <= '0;
                    r_wr_sel <= ~r_wr_sel;
                end else begin
                    r_idx <= w_wr_idx + IDX_W'(1);
                end
            end
            if (w_consume) r_rd_sel <= ~r_rd_sel;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft4_framer_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .i_we  (w_wr_en[g]),
            .i_idx (w_wr_idx),
            .i_re  (bus.s_re),
            .i_im  (bus.s_im),
            .o_re  (w_bank_re[g]),
            .o_im  (w_bank_im[g])
        );
    end

    assign bus.x0_re = w_bank_re[r_rd_sel][0];
    assign bus.x0_im = w_bank_im[r_rd_sel][0];
    assign bus.x1_re = w_bank_re[r_rd_sel][1];
    assign bus.x1_im = w_bank_im[r_rd_sel][1];
    assign bus.x2_re = w_bank_re[r_rd_sel][2];
    assign bus.x2_im = w_bank_im[r_rd_sel][2];
    assign bus.x3_re = w_bank_re[r_rd_sel][3];
    assign bus.x3_im = w_bank_im[r_rd_sel][3];

    assign bus.err_misalign = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fft4_input_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft4_input_framer
//  Description : Self-checking bench for fft4_input_framer. A frame-level
//                model (partial-frame queue plus pending-frame queue) predicts
//                s_ready, m_valid, the presented frame and err_misalign.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft4_input_framer;
    import fft4_pkg::*;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft4_input_framer_if #(.DATA_W(DW)) bus ();

    fft4_input_framer #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    cplx_t        part_q[$];   // samples of the frame being assembled
    logic [127:0] frm_q[$];    // completed frames not yet consumed
    logic         err_exp;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] frame_obs();
        return {bus.x0_re, bus.x0_im, bus.x1_re, bus.x1_im,
                bus.x2_re, bus.x2_im, bus.x3_re, bus.x3_im};
    endfunction

    task automatic check_outputs();
        chk("s_ready", 128'(bus.s_ready), 128'(frm_q.size() < 2));
        chk("m_valid", 128'(bus.m_valid), 128'(frm_q.size() > 0));
        chk("err_misalign", 128'(bus.err_misalign), 128'(err_exp));
        if (frm_q.size() > 0) chk("frame", frame_obs(), frm_q[0]);
    endtask

    // One clock cycle: check outputs, drive inputs, advance, update model.
    task automatic step(input bit v, input bit sof, input logic [DW-1:0] re,
                        input logic [DW-1:0] im, input bit mr);
        bit    acc;
        bit    cons;
        cplx_t s;
        check_outputs();
        bus.s_valid = v;
        bus.s_sof   = sof;
        bus.s_re    = re;
        bus.s_im    = im;
        bus.m_ready = mr;
        acc  = v && (frm_q.size() < 2);
        cons = mr && (frm_q.size() > 0);
        @(posedge clk);
        if (cons) void'(frm_q.pop_front());
        err_exp = 1'b0;
        if (acc) begin
            if (sof && part_q.size() != 0) begin
                part_q.delete();
                err_exp = 1'b1;
            end
            s.re = re;
            s.im = im;
            part_q.push_back(s);
            if (part_q.size() == FFT_N) begin
                frm_q.push_back({part_q[0], part_q[1], part_q[2], part_q[3]});
                part_q.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_re    = '0;
        bus.s_im    = '0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        part_q.delete();
        frm_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", 128'(bus.m_valid), 128'(0));
        chk("rst_s_ready", 128'(bus.s_ready), 128'(1));
        chk("rst_err", 128'(bus.err_misalign), 128'(0));
        chk("rst_frame_zero", frame_obs(), 128'(0));
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, mr);
    endtask

    initial begin
        err_exp = 1'b0;
        @(negedge clk);
        do_reset();

        // Single frame, held under backpressure, then consumed
        for (int i = 1; i <= 4; i++) step(1'b1, i == 1, 16'(i), 16'h0, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Both banks fill, s_ready drops, one pulse frees a bank
        for (int i = 1; i <= 8; i++) step(1'b1, (i % 4) == 1, 16'(i), 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'd9, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'd9, 16'h0, 1'b1);
        for (int i = 9; i <= 12; i++) step(1'b1, i == 9, 16'(i), 16'h0, 1'b0);
        idle(1, 1'b0);
        idle(4, 1'b1);

        // Sustained rate with m_ready high, includes same-cycle read/write
        for (int i = 0; i < 16; i++) step(1'b1, (i % 4) == 0, 16'(i), 16'(100 + i), 1'b1);
        idle(3, 1'b1);

        // Misaligned start-of-frame
        step(1'b1, 1'b1, 16'd10, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'd11, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'd20, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'd21, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'd22, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'd23, 16'h0, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Reset with one frame pending and two samples filling
        for (int i = 0; i < 6; i++) step(1'b1, (i % 4) == 0, 16'(50 + i), 16'hFFFF, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 16'(70 + i), 16'(16'h8000 + i), 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 4) != 0, ($urandom % 8) == 0,
                 16'($urandom), 16'($urandom), ($urandom % 3) != 0);
        end
        idle(6, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
